// File: rtl/axilite_noc_request.sv
// axilite_noc_request
//   AXI-Lite slave front end that turns read (AR) and write (AW+W) requests
//   into OpenPiton NoC request packets: header0, header1, header2 and, for
//   stores, N = AXI_LITE_DATA_WIDTH/NOC_DATA_WIDTH data flits (LS flit first).
//   Outstanding requests are counted per direction and released by the
//   response stage's completion pulses. This keeps its data FIFO from overflowing.
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   src_chipid/src_x/src_y         source coordinates placed in header2
//   s_axi_ar*                      read address channel
//   s_axi_aw*                      write address channel
//   s_axi_w*                       write data channel (wstrb ignored)
//   noc_valid_out/noc_data_out/noc_ready_in   NoC request flit stream
//   rd_resp_done, wr_resp_done     one-cycle completion pulses
//
// Build option
//   AXILITE_NOC_SWAP_ENDIAN_EN : byte-reverse each store data flit.
//                                Headers are never swapped.
module axilite_noc_request #(
  parameter int          AXI_LITE_ADDR_WIDTH = 40,
  parameter int          AXI_LITE_DATA_WIDTH = 64,
  parameter int          MAX_OUTSTANDING     = 4,
  parameter logic [2:0]  REQ_SIZE            = 3'b100,
  parameter logic [13:0] DST_CHIPID          = '0,
  parameter logic [7:0]  DST_X               = '0,
  parameter logic [7:0]  DST_Y               = '0,
  parameter logic [3:0]  DST_FBITS           = '0,
  localparam int NOC_DATA_WIDTH   = 64,
  localparam int NOC_CHIPID_WIDTH = 14,
  localparam int NOC_X_WIDTH      = 8,
  localparam int NOC_Y_WIDTH      = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NOC_CHIPID_WIDTH-1:0]      src_chipid,
  input  logic [NOC_X_WIDTH-1:0]           src_x,
  input  logic [NOC_Y_WIDTH-1:0]           src_y,
  input  logic [AXI_LITE_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                             s_axi_arvalid,
  output logic                             s_axi_arready,
  input  logic [AXI_LITE_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                             s_axi_awvalid,
  output logic                             s_axi_awready,
  input  logic [AXI_LITE_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [AXI_LITE_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                             s_axi_wvalid,
  output logic                             s_axi_wready,
  output logic                             noc_valid_out,
  output logic [NOC_DATA_WIDTH-1:0]        noc_data_out,
  input  logic                             noc_ready_in,
  input  logic                             rd_resp_done,
  input  logic                             wr_resp_done
);

  localparam int               N         = AXI_LITE_DATA_WIDTH / NOC_DATA_WIDTH;
  localparam int               IDX_W     = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);
  localparam logic [3:0]       MAX_CNT   = 4'(MAX_OUTSTANDING);
  localparam logic [7:0]       MSG_TYPE_NC_LOAD_REQ  = 8'd14;
  localparam logic [7:0]       MSG_TYPE_NC_STORE_REQ = 8'd15;

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, HDR2, DATA} state_t;
  typedef struct packed {
    logic                           full;
    logic [AXI_LITE_ADDR_WIDTH-1:0] addr;
  } addr_buf_t;
  typedef struct packed {
    logic                           full;
    logic [AXI_LITE_DATA_WIDTH-1:0] data;
  } data_buf_t;

  state_t           state;
  addr_buf_t        ar_buf, aw_buf;
  data_buf_t        w_buf;
  logic [3:0]       rd_cnt, wr_cnt;
  logic [7:0]       tag;
  logic             init, rr_wr, cur_wr;
  logic [IDX_W-1:0] idx;

  logic unused_wstrb;
  assign unused_wstrb = ^s_axi_wstrb;

  // init holds the readies low until the first edge after reset release
  assign s_axi_arready = init && !ar_buf.full && (rd_cnt < MAX_CNT);
  assign s_axi_awready = init && !aw_buf.full && (wr_cnt < MAX_CNT);
  assign s_axi_wready  = init && !w_buf.full  && (wr_cnt < MAX_CNT);

  logic ar_hs, aw_hs, w_hs, noc_acc, rd_dec, wr_dec;
  assign ar_hs   = s_axi_arvalid && s_axi_arready;
  assign aw_hs   = s_axi_awvalid && s_axi_awready;
  assign w_hs    = s_axi_wvalid  && s_axi_wready;
  assign noc_acc = noc_valid_out && noc_ready_in;
  // a completion pulse with nothing outstanding is dropped
  assign rd_dec  = rd_resp_done && (rd_cnt != '0);
  assign wr_dec  = wr_resp_done && (wr_cnt != '0);

  logic rd_el, wr_el, pick_wr;
  assign rd_el   = ar_buf.full;
  assign wr_el   = aw_buf.full && w_buf.full;
  assign pick_wr = wr_el && (!rd_el || rr_wr);

  function automatic logic [63:0] mk_hdr0(input logic wr, input logic [7:0] t);
    logic [63:0] h;
    h        = '0;
    h[63:50] = DST_CHIPID;
    h[49:42] = DST_X;
    h[41:34] = DST_Y;
    h[33:30] = DST_FBITS;
    h[29:22] = wr ? 8'(2 + N) : 8'd2;
    h[21:14] = wr ? MSG_TYPE_NC_STORE_REQ : MSG_TYPE_NC_LOAD_REQ;
    h[13:6]  = t;
    return h;
  endfunction

`ifdef AXILITE_NOC_SWAP_ENDIAN_EN
  function automatic logic [NOC_DATA_WIDTH-1:0] byte_swap(input logic [NOC_DATA_WIDTH-1:0] d);
    logic [NOC_DATA_WIDTH-1:0] r;
    for (int b = 0; b < NOC_DATA_WIDTH/8; b++)
      r[b*8 +: 8] = d[NOC_DATA_WIDTH-8-b*8 +: 8];
    return r;
  endfunction
`endif

  logic [AXI_LITE_ADDR_WIDTH-1:0] cur_addr;
  logic [63:0]                    hdr1, hdr2;
  logic [IDX_W-1:0]               flit_idx;
  logic [AXI_LITE_DATA_WIDTH-1:0] flit_shift;
  logic [NOC_DATA_WIDTH-1:0]      data_flit;

  always_comb begin
    cur_addr     = cur_wr ? aw_buf.addr : ar_buf.addr;
    hdr1         = '0;
    hdr1[63:16]  = 48'(cur_addr);
    hdr1[15:13]  = REQ_SIZE;
    hdr2         = '0;
    hdr2[63:50]  = src_chipid;
    hdr2[49:42]  = src_x;
    hdr2[41:34]  = src_y;
    // next data flit: first one when leaving HDR2, otherwise the following one
    flit_idx     = (state == DATA) ? idx + 1'b1 : '0;
    flit_shift   = w_buf.data >> (NOC_DATA_WIDTH * int'(flit_idx));
`ifdef AXILITE_NOC_SWAP_ENDIAN_EN
    data_flit    = byte_swap(flit_shift[NOC_DATA_WIDTH-1:0]);
`else
    data_flit    = flit_shift[NOC_DATA_WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ar_buf        <= '0;
      aw_buf        <= '0;
      w_buf         <= '0;
      rd_cnt        <= '0;
      wr_cnt        <= '0;
      tag           <= '0;
      init          <= 1'b0;
      rr_wr         <= 1'b0;
      cur_wr        <= 1'b0;
      idx           <= '0;
      noc_valid_out <= 1'b0;
      noc_data_out  <= '0;
    end else begin
      init <= 1'b1;
      if (ar_hs) ar_buf <= '{full: 1'b1, addr: s_axi_araddr};
      if (aw_hs) aw_buf <= '{full: 1'b1, addr: s_axi_awaddr};
      if (w_hs)  w_buf  <= '{full: 1'b1, data: s_axi_wdata};

      if (ar_hs && !rd_dec)      rd_cnt <= rd_cnt + 4'd1;
      else if (!ar_hs && rd_dec) rd_cnt <= rd_cnt - 4'd1;
      if (aw_hs && !wr_dec)      wr_cnt <= wr_cnt + 4'd1;
      else if (!aw_hs && wr_dec) wr_cnt <= wr_cnt - 4'd1;

      case (state)
        IDLE: if (rd_el || wr_el) begin
          cur_wr <= pick_wr;
          // the round-robin bit only moves when both directions contend
          if (rd_el && wr_el) rr_wr <= !pick_wr;
          noc_valid_out <= 1'b1;
          noc_data_out  <= mk_hdr0(pick_wr, tag);
          state         <= HDR0;
        end
        HDR0: if (noc_acc) begin
          noc_data_out <= hdr1;
          tag          <= tag + 8'd1;
          state        <= HDR1;
        end
        HDR1: if (noc_acc) begin
          noc_data_out <= hdr2;
          state        <= HDR2;
        end
        HDR2: if (noc_acc) begin
          if (cur_wr) begin
            noc_data_out <= data_flit;
            idx          <= '0;
            state        <= DATA;
          end else begin
            noc_valid_out <= 1'b0;
            ar_buf.full   <= 1'b0;
            state         <= IDLE;
          end
        end
        DATA: if (noc_acc) begin
          if (idx == LAST_IDX) begin
            noc_valid_out <= 1'b0;
            aw_buf.full   <= 1'b0;
            w_buf.full    <= 1'b0;
            state         <= IDLE;
          end else begin
            noc_data_out <= data_flit;
            idx          <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axilite_noc_request.md
# axilite_noc_request

Upstream stage of `noc_response_axilite`: an AXI-Lite slave that accepts read (AR) and write (AW+W) requests and serializes each into an OpenPiton NoC request packet (header0..2 plus store data flits) toward the memory/IO splitter. It tracks outstanding requests per direction and releases credits on completion pulses from the response stage, so the response stage's data FIFO cannot overflow.

## Interface
Parameters:
- `AXI_LITE_ADDR_WIDTH`, 40: request address width, zero-extended into `MSG_ADDR_`.
- `AXI_LITE_DATA_WIDTH`, 64: must be an integer multiple (1..8) of `NOC_DATA_WIDTH`.
- `MAX_OUTSTANDING`, 4: per-direction outstanding request limit, 1..15.
- `REQ_SIZE`, 3'b100: value driven into `MSG_DATA_SIZE_` for every request.
- `DST_CHIPID`, `DST_X`, `DST_Y`, `DST_FBITS`, 0: destination fields in header0.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `src_chipid` in `NOC_CHIPID_WIDTH`, `src_x` in `NOC_X_WIDTH`, `src_y` in `NOC_Y_WIDTH`: source fields in header2.
- `s_axi_araddr` in ADDR, `s_axi_arvalid` in 1, `s_axi_arready` out 1: read address channel.
- `s_axi_awaddr` in ADDR, `s_axi_awvalid` in 1, `s_axi_awready` out 1: write address channel.
- `s_axi_wdata` in DATA, `s_axi_wstrb` in DATA/8, `s_axi_wvalid` in 1, `s_axi_wready` out 1: write data channel. `wstrb` is ignored.
- `noc_valid_out` out 1, `noc_data_out` out `NOC_DATA_WIDTH`, `noc_ready_in` in 1: NoC request flits.
- `rd_resp_done` in 1, `wr_resp_done` in 1: one-cycle completion pulses from the response stage.

## Operation
- Three single-entry capture buffers: AR, AW and W.
  - Each ready is high iff its buffer is empty, the direction's outstanding count is below `MAX_OUTSTANDING`, and the init flag is set.
  - A buffer fills on its handshake.
- Outstanding counters `rd_cnt` and `wr_cnt`:
  - `rd_cnt` increments on the AR handshake; `wr_cnt` increments on the AW handshake.
  - Each decrements on its done pulse. A simultaneous increment and decrement leaves the count unchanged.
  - A done pulse at count 0 is ignored; the count does not wrap.
- FSM states: IDLE, HDR0, HDR1, HDR2, DATA.
  - IDLE: a read is eligible when the AR buffer is full. A write is eligible when both the AW and W buffers are full.
  - IDLE arbitration: a round-robin bit picks between eligible read and write, favouring the direction not served last; the bit resets to favour read. The winner latches and the FSM goes to HDR0.
  - HDR0 → HDR1 → HDR2: each advances on `noc_valid_out && noc_ready_in`.
  - After HDR2: a read returns to IDLE and frees the AR buffer. A write goes to DATA.
  - DATA: sends N = `AXI_LITE_DATA_WIDTH`/`NOC_DATA_WIDTH` flits, least-significant flit first. On the last accepted flit it frees the AW and W buffers and goes to IDLE.
- Header0:
  - `MSG_TYPE`: `MSG_TYPE_NC_LOAD_REQ` for a read, `MSG_TYPE_NC_STORE_REQ` for a write.
  - `MSG_LENGTH`: 2 for a read, 2+N for a write.
  - `MSG_MSHRID`: 8-bit tag counter, zero-extended. It increments after each header0 is accepted and wraps 255→0.
  - Destination fields come from the parameters; all other bits are 0.
- Header1: `MSG_ADDR_` = captured address; `MSG_DATA_SIZE_` = `REQ_SIZE`; other bits 0.
- Header2: `MSG_SRC_CHIPID_`, `MSG_SRC_X_`, `MSG_SRC_Y_` from the src ports; `MSG_SRC_FBITS_` = 0; other bits 0.

## Timing
- Reset values: `noc_valid_out`=0, `noc_data_out`=0, FSM=IDLE, buffers empty, counters 0, tag 0.
- Ready outputs are 0 while `rst_n` is low. A registered init flag sets them high from the first `clk` edge after release.
- Flit output registers hold stable while `noc_valid_out && !noc_ready_in`.
- Latency with `noc_ready_in` held high:
  - AR handshake at cycle t → header0 valid at t+2, last flit at t+4.
  - Write with AW and W both handshaken at t → header0 at t+2, last data flit at t+4+N.
- A freed buffer reasserts its ready the cycle after the freeing flit is accepted.
- AW and W may arrive in any order or cycle. A write is not eligible until both are captured.
- Reset asserted mid-packet aborts the packet: `noc_valid_out` drops immediately (asynchronously) and all state clears.

## Configuration
- `AXILITE_NOC_SWAP_ENDIAN_EN`:
  - Defined: each store data flit is byte-reversed within its `NOC_DATA_WIDTH` bits before output.
  - Undefined: data passes unmodified.
  - Headers are never swapped.

## Test plan
- AR addr 0x12_3456_7840, `noc_ready_in`=1 → three flits.
  - Header0: type NC_LOAD_REQ, length 2, mshrid 0.
  - Header1: addr 0x12_3456_7840.
  - Then `arready` high again.
- AW at cycle 0, W data 0xDEAD_BEEF_0123_4567 at cycle 5 → header0 (length 3) appears 2 cycles after the W handshake, then data flit 0xDEAD_BEEF_0123_4567. With the macro defined, the data flit is 0x6745_2301_EFBE_ADDE.
- AR and AW+W captured in the same cycle → read packet first, then write packet. A second simultaneous pair → write packet first.
- Four reads with `MAX_OUTSTANDING`=4 and no `rd_resp_done` → `arready`=0. One `rd_resp_done` pulse → `arready`=1 next cycle. A done pulse in the same cycle as an AR handshake → count unchanged.
- `noc_ready_in` low for 10 cycles during HDR1 → the same header1 is held stable and the FSM does not advance. After 256 requests, mshrid wraps to 0.
- `rst_n` pulsed low during the DATA state → `noc_valid_out`=0 at once. After release: ready outputs go high after one edge, and a new AR produces mshrid 0.
